otter_mem_arbiter: RTL and testbench
====================================

Name: otter_mem_arbiter

Overview:
- Shares the single OTTER memory port between three requesters:
  - 0 = instruction fetch (driven by the control FSM's fetch read)
  - 1 = CPU data load/store
  - 2 = external master (DMA/debug)
- Rotating-priority arbitration, one transaction at a time, with a request/acknowledge handshake on both sides.
- Sits between the multicycle CPU and the memory, so the FSM can stall fetch and load/store while an external master owns the port.

Parameters:
- ADDR_W, 32, address width of every requester and the memory port.
- DATA_W, 32, read/write data width.
- TIMEOUT, 15, cycles to wait for MEM_ACK before aborting (used only with ARB_TIMEOUT_EN; legal 1..255).

Ports:
- ARB_CLK  in  1  clock; all state updates on its rising edge.
- ARB_RESET  in  1  asynchronous, active-high reset.
- REQ  in  3  per-requester request, bit i = requester i.
- WE  in  3  per-requester write enable; bit 0 is ignored (fetch is always a read).
- ADDR0, ADDR1, ADDR2  in  ADDR_W each  per-requester address.
- WDATA1, WDATA2  in  DATA_W each  write data.
- SIZE1, SIZE2  in  2 each  access size: 00 = byte, 01 = half, 10 = word. Fetch is always word.
- ACK  out  3  one-cycle completion pulse, bit i = requester i.
- GNT  out  3  one-hot current owner; all zero when idle.
- RDATA  out  DATA_W  registered read data, valid while ACK is high.
- ERR  out  1  high with ACK when the transaction timed out.
- MEM_REQ  out  1  memory request.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_SIZE  out  2  memory access size.
- MEM_ACK  in  1  memory completion; MEM_RDATA is valid in the same cycle.
- MEM_RDATA  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - State goes to IDLE.
  - All outputs go to 0, including MEM_REQ, GNT, ACK, ERR and RDATA.
  - Priority pointer resets to 0, giving order 0 > 1 > 2.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - If any REQ bit is high at the clock edge, grant the first set bit found searching from the pointer upward, with wrap-around (pointer, pointer+1, pointer+2 mod 3).
  - At that edge, register GNT and the winner's WE/ADDR/WDATA/SIZE into the MEM_* outputs, set MEM_REQ=1, and go to BUSY.
  - With no requests, stay in IDLE with all outputs 0.
- BUSY:
  - MEM_* outputs are held constant.
  - On an edge with MEM_ACK=1: capture MEM_RDATA into RDATA (always, including writes), drop MEM_REQ, set ACK[gnt]=1, go to DONE.
  - Latency from REQ sampled to ACK high is therefore 2 cycles plus memory wait cycles.
- DONE (exactly one cycle):
  - ACK pulses high for this one cycle.
  - GNT is still valid.
  - Pointer moves to (granted index + 1) mod 3.
  - Next state is IDLE with ACK and GNT cleared.
- Requester rules:
  - Hold REQ and all request fields stable from assertion until ACK is seen.
  - Drop REQ at the edge that ends the ACK cycle.
  - REQ still high in IDLE is treated as a new request.
- MEM_ACK outside BUSY is ignored.
- REQ changes on non-granted inputs during BUSY or DONE have no effect until IDLE.
- Simultaneous requests: strictly rotating. Under continuous requests from all three, grants go 0,1,2,0,...

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle without MEM_ACK.
  - When the count reaches TIMEOUT: drop MEM_REQ, set RDATA=0, set ERR=1 together with ACK[gnt] for the DONE cycle, then continue as normal.
  - If MEM_ACK arrives on the same edge the count reaches TIMEOUT, MEM_ACK wins and ERR=0.
- Not defined: no counter; BUSY waits indefinitely and ERR is tied to 0.

Test Plan:
- Reset, then REQ=001, ADDR0=0x100, memory acks after 1 cycle with 0xDEADBEEF:
  - MEM_REQ is high 1 cycle after the REQ sample.
  - ACK=001 with RDATA=0xDEADBEEF one cycle after MEM_ACK.
  - GNT=001 during BUSY and DONE.
- REQ=111 held continuously, memory acks immediately, for 6 transactions:
  - Grant order is 0,1,2,0,1,2.
  - Each ACK lasts exactly 1 cycle.
- REQ=010, WE=010, ADDR1=0x2000, WDATA1=0x12345678, SIZE1=01:
  - MEM_WE=1, MEM_ADDR=0x2000, MEM_WDATA=0x12345678 and MEM_SIZE=01, all held stable until MEM_ACK.
- Assert ARB_RESET mid-BUSY while requester 2 is granted:
  - MEM_REQ and GNT go to 0 in the same cycle, before any clock edge.
  - After release with REQ=101, requester 0 is granted first.
- With ARB_TIMEOUT_EN, TIMEOUT=15, MEM_ACK held at 0:
  - ACK plus ERR=1 and RDATA=0 on the 17th cycle after the REQ sample.
  - The next request completes normally with ERR=0.
- Without ARB_TIMEOUT_EN, MEM_ACK withheld for 40 cycles:
  - Stays in BUSY, MEM_REQ stays high, ERR stays 0.
  - Completes normally once MEM_ACK is asserted.

Source files
------------

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter: shares the single OTTER memory port between instruction
// fetch (0), CPU load/store (1) and an external master (2). Rotating priority,
// one transaction at a time, IDLE -> BUSY -> DONE handshake.
// Optional macro ARB_TIMEOUT_EN: abort a transaction after TIMEOUT cycles
// without MEM_ACK, returning ERR=1 and RDATA=0.
module otter_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              ARB_CLK,
   input  logic              ARB_RESET,
   input  logic [2:0]        REQ,
   input  logic [2:0]        WE,
   input  logic [ADDR_W-1:0] ADDR0,
   input  logic [ADDR_W-1:0] ADDR1,
   input  logic [ADDR_W-1:0] ADDR2,
   input  logic [DATA_W-1:0] WDATA1,
   input  logic [DATA_W-1:0] WDATA2,
   input  logic [1:0]        SIZE1,
   input  logic [1:0]        SIZE2,
   output logic [2:0]        ACK,
   output logic [2:0]        GNT,
   output logic [DATA_W-1:0] RDATA,
   output logic              ERR,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic [1:0]        MEM_SIZE,
   input  logic              MEM_ACK,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   state_t            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [2:0]        gnt_q, gnt_d;
   logic [2:0]        ack_q, ack_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [1:0]        mem_size_q, mem_size_d;
`ifdef ARB_TIMEOUT_EN
   logic              err_q, err_d;
   logic [7:0]        cnt_q, cnt_d;
`endif

   // fetch is always a word read, so its write enable is never looked at
   logic unused_we0;
   assign unused_we0 = WE[0];

   logic [2:0]        win_oh;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        sel_size;

   // pick the first requester at or after the pointer, wrapping around
   always_comb begin
      win_oh = 3'b000;
      case (ptr_q)
         2'd1: begin
            if (REQ[1])      win_oh = 3'b010;
            else if (REQ[2]) win_oh = 3'b100;
            else if (REQ[0]) win_oh = 3'b001;
         end
         2'd2: begin
            if (REQ[2])      win_oh = 3'b100;
            else if (REQ[0]) win_oh = 3'b001;
            else if (REQ[1]) win_oh = 3'b010;
         end
         default: begin
            if (REQ[0])      win_oh = 3'b001;
            else if (REQ[1]) win_oh = 3'b010;
            else if (REQ[2]) win_oh = 3'b100;
         end
      endcase
   end

   // route the winner's request fields toward the memory port
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = ADDR0;
      sel_wdata = '0;
      sel_size  = 2'b10;
      case (win_oh)
         3'b010: begin
            sel_we    = WE[1];
            sel_addr  = ADDR1;
            sel_wdata = WDATA1;
            sel_size  = SIZE1;
         end
         3'b100: begin
            sel_we    = WE[2];
            sel_addr  = ADDR2;
            sel_wdata = WDATA2;
            sel_size  = SIZE2;
         end
         default: ;
      endcase
   end

   // next-state and output logic for the IDLE/BUSY/DONE handshake
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_d       = gnt_q;
      ack_d       = ack_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_size_d  = mem_size_q;
`ifdef ARB_TIMEOUT_EN
      err_d       = err_q;
      cnt_d       = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (|REQ) begin
               gnt_d       = win_oh;
               mem_req_d   = 1'b1;
               mem_we_d    = sel_we;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_wdata;
               mem_size_d  = sel_size;
               state_d     = BUSY;
`ifdef ARB_TIMEOUT_EN
               cnt_d       = 8'd0;
`endif
            end
         end
         BUSY: begin
            if (MEM_ACK) begin
               // read data is captured even for writes; memory defines its value
               rdata_d     = MEM_RDATA;
               ack_d       = gnt_q;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               mem_size_d  = 2'b00;
               state_d     = DONE;
`ifdef ARB_TIMEOUT_EN
               err_d       = 1'b0;
            end else if (cnt_q == 8'(TIMEOUT)) begin
               // memory never answered: abort and flag the owner
               rdata_d     = '0;
               err_d       = 1'b1;
               ack_d       = gnt_q;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               mem_size_d  = 2'b00;
               state_d     = DONE;
            end else begin
               cnt_d       = cnt_q + 8'd1;
`endif
            end
         end
         DONE: begin
            // advance priority past whoever just finished
            case (gnt_q)
               3'b001:  ptr_d = 2'd1;
               3'b010:  ptr_d = 2'd2;
               default: ptr_d = 2'd0;
            endcase
            ack_d   = 3'b000;
            gnt_d   = 3'b000;
            rdata_d = '0;
            state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
            err_d   = 1'b0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // state and output registers; reset clears everything immediately
   always_ff @(posedge ARB_CLK or posedge ARB_RESET) begin
      if (ARB_RESET) begin
         state_q     <= IDLE;
         ptr_q       <= 2'd0;
         gnt_q       <= 3'b000;
         ack_q       <= 3'b000;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_size_q  <= 2'b00;
`ifdef ARB_TIMEOUT_EN
         err_q       <= 1'b0;
         cnt_q       <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_q       <= gnt_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_size_q  <= mem_size_d;
`ifdef ARB_TIMEOUT_EN
         err_q       <= err_d;
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign GNT       = gnt_q;
   assign ACK       = ack_q;
   assign RDATA     = rdata_q;
   assign MEM_REQ   = mem_req_q;
   assign MEM_WE    = mem_we_q;
   assign MEM_ADDR  = mem_addr_q;
   assign MEM_WDATA = mem_wdata_q;
   assign MEM_SIZE  = mem_size_q;
`ifdef ARB_TIMEOUT_EN
   assign ERR       = err_q;
`else
   assign ERR       = 1'b0;
`endif

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: the bench plays requesters and memory; a
// rotating-priority model (integer pointer + search loop) predicts winners.
module tb_otter_mem_arbiter;
   localparam int TO = 15;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  REQ, WE, ACK, GNT;
   logic [31:0] ADDR0, ADDR1, ADDR2, WDATA1, WDATA2, RDATA;
   logic [1:0]  SIZE1, SIZE2, MEM_SIZE;
   logic        ERR, MEM_REQ, MEM_WE, MEM_ACK;
   logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

   always #5 clk = ~clk;

   otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
      .ARB_CLK(clk), .ARB_RESET(rst), .REQ(REQ), .WE(WE),
      .ADDR0(ADDR0), .ADDR1(ADDR1), .ADDR2(ADDR2),
      .WDATA1(WDATA1), .WDATA2(WDATA2), .SIZE1(SIZE1), .SIZE2(SIZE2),
      .ACK(ACK), .GNT(GNT), .RDATA(RDATA), .ERR(ERR),
      .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
      .MEM_WDATA(MEM_WDATA), .MEM_SIZE(MEM_SIZE),
      .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   int          ptr_m = 0;
   logic [2:0]  cur_mask;
   logic [31:0] f_addr [3];
   logic [31:0] f_wd   [3];
   logic        f_we   [3];
   logic [1:0]  f_sz   [3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [2:0] m, input int p);
      for (int k = 0; k < 3; k++)
         if (m[(p + k) % 3]) return (p + k) % 3;
      return 0;
   endfunction

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   task automatic drive();
      REQ    = cur_mask;
      WE     = {f_we[2], f_we[1], f_we[0]};
      ADDR0  = f_addr[0];
      ADDR1  = f_addr[1];
      ADDR2  = f_addr[2];
      WDATA1 = f_wd[1];
      WDATA2 = f_wd[2];
      SIZE1  = f_sz[1];
      SIZE2  = f_sz[2];
   endtask

   task automatic rand_fields();
      for (int i = 0; i < 3; i++) begin
         f_addr[i] = $urandom;
         f_wd[i]   = $urandom;
         f_we[i]   = 1'($urandom_range(0, 1));
         f_sz[i]   = 2'($urandom_range(0, 2));
      end
   endtask

   // one transaction, entered on a negedge with REQ already driven and the
   // arbiter idle; leaves on the negedge after the ACK cycle
   task automatic do_txn(input int w, input logic [31:0] rd, input bit keep);
      int         win, k, nw;
      bit         to;
      logic       e_we;
      logic [1:0] e_sz;
      win = pick(cur_mask, ptr_m);
`ifdef ARB_TIMEOUT_EN
      to = (w > TO);
`else
      to = 1'b0;
`endif
      k = 0;
      while (MEM_REQ !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k >= 20) begin
         n_cmp++; n_bad++;
         $error("FAIL grant_wait: observed no MEM_REQ after %0d cycles, required 1", k);
         finish_run();
      end
      chk("req_to_memreq_cycles", k, 1);
      e_we = (win == 0) ? 1'b0 : f_we[win];
      e_sz = (win == 0) ? 2'b10 : f_sz[win];
      chk("gnt", GNT, 32'(1 << win));
      chk("mem_we", MEM_WE, e_we);
      chk("mem_addr", MEM_ADDR, f_addr[win]);
      chk("mem_size", MEM_SIZE, e_sz);
      if (win != 0) chk("mem_wdata", MEM_WDATA, f_wd[win]);
      chk("ack_busy", ACK, 0);
      nw = to ? TO : w;
      for (int i = 0; i < nw; i++) begin
         @(negedge clk);
         chk("memreq_hold", MEM_REQ, 1);
         chk("addr_hold", MEM_ADDR, f_addr[win]);
         chk("we_hold", MEM_WE, e_we);
         chk("size_hold", MEM_SIZE, e_sz);
         chk("err_busy", ERR, 0);
         chk("ack_busy", ACK, 0);
      end
      if (!to) begin
         MEM_ACK   = 1'b1;
         MEM_RDATA = rd;
      end
      @(negedge clk);
      MEM_ACK   = 1'b0;
      MEM_RDATA = $urandom;
      chk("ack", ACK, 32'(1 << win));
      chk("rdata", RDATA, to ? 32'h0 : rd);
      chk("err", ERR, 32'(to));
      chk("gnt_done", GNT, 32'(1 << win));
      chk("memreq_done", MEM_REQ, 0);
      ptr_m = (win + 1) % 3;
      if (!keep) begin
         cur_mask[win] = 1'b0;
         drive();
      end
      @(negedge clk);
      chk("ack_pulse_end", ACK, 0);
      chk("gnt_idle", GNT, 0);
      chk("err_idle", ERR, 0);
   endtask

   initial begin
      #500000;
      n_cmp++; n_bad++;
      $error("FAIL watchdog: observed time limit reached, required completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; MEM_ACK = 1'b0; MEM_RDATA = '0;
      for (int i = 0; i < 3; i++) begin
         f_addr[i] = '0; f_wd[i] = '0; f_we[i] = 1'b0; f_sz[i] = 2'b00;
      end
      cur_mask = 3'b000;
      drive();
      repeat (2) @(negedge clk);
      chk("rst_memreq", MEM_REQ, 0);
      chk("rst_gnt", GNT, 0);
      chk("rst_ack", ACK, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_err", ERR, 0);
      rst = 1'b0;
      @(negedge clk);

      // fetch read, one memory wait cycle
      f_addr[0] = 32'h100;
      cur_mask  = 3'b001;
      drive();
      do_txn(1, 32'hDEADBEEF, 0);

      // half-word store from the CPU data port
      f_we[1] = 1'b1; f_addr[1] = 32'h2000; f_wd[1] = 32'h12345678; f_sz[1] = 2'b01;
      cur_mask = 3'b010;
      drive();
      do_txn(3, 32'hA5A5_0001, 0);

      // reset in the middle of an external-master transaction
      rand_fields();
      cur_mask = 3'b100;
      drive();
      @(negedge clk);
      chk("pre_rst_memreq", MEM_REQ, 1);
      chk("pre_rst_gnt", GNT, 3'b100);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_memreq", MEM_REQ, 0);
      chk("async_rst_gnt", GNT, 0);
      @(negedge clk);
      rst = 1'b0;
      ptr_m = 0;
      cur_mask = 3'b101;
      drive();
      do_txn(0, $urandom, 0);
      do_txn(0, $urandom, 0);

      // all three requesting continuously: strict rotation
      rand_fields();
      cur_mask = 3'b111;
      drive();
      for (int i = 0; i < 6; i++) do_txn(0, $urandom, 1);
      cur_mask = 3'b000;
      drive();
      @(negedge clk);

      // slow memory: long wait (aborts with the timeout feature)
      rand_fields();
      cur_mask = 3'b100;
      drive();
      do_txn(40, 32'hCAFE_F00D, 1);
      do_txn(TO, 32'h0BAD_CAFE, 1);
      do_txn(2, 32'h1357_9BDF, 0);

      // random request sets and memory latencies
      for (int r = 0; r < 10; r++) begin
         rand_fields();
         cur_mask = 3'($urandom_range(1, 7));
         drive();
         while (cur_mask != 3'b000) do_txn(int'($urandom_range(0, 3)), $urandom, 0);
      end

      finish_run();
   end
endmodule
